comb_share_arbiter: RTL and testbench
=====================================

# comb_share_arbiter

Round-robin arbiter that time-shares a single `comb00` inverter stage among `NREQ` requesters. Each requester presents an 8-bit operand with a level request. The arbiter grants one requester at a time, drives its operand through the shared stage, and returns the registered result with a one-cycle acknowledge. It is the scheduling alternative to the per-lane replicated array: one datapath instance plus control instead of N instances.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `IDW`, default `$clog2(NREQ)`: requester-index width; derived, do not override.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_i`  in  NREQ: level request per requester.
- `data_i`  in  8*NREQ: operands; requester n on `[8n+7:8n]`.
- `ack_o`  out  NREQ: one-cycle completion pulse, one-hot.
- `res_o`  out  8: registered result; holds until the next completion.
- `res_valid_o`  out  1: one-cycle pulse, coincident with `ack_o`.
- `res_id_o`  out  IDW: index of the requester being acknowledged; holds like `res_o`.
- `busy_o`  out  1: high in EXEC and ACK.
- `xfer_cnt_o`  out  16: completed transactions, wraps 0xFFFF to 0.
- `err_o`  out  1: sticky protocol error; cleared only by `rst`.

## Operation
- Exactly one internal `comb00` instance. Its input is the operand register; its output is `~operand`.
- FSM states: IDLE, EXEC, ACK.
- **IDLE:**
  - If any `req_i` bit is high, select a winner by round-robin.
  - Search order starts at `last_id+1` and wraps modulo NREQ.
  - Latch `operand <= data_i[winner]` and `cur_id <= winner`, then go to EXEC.
  - With no requests, stay in IDLE.
- **EXEC:**
  - `res_o <= ~operand`, `res_id_o <= cur_id`.
  - Pulse `res_valid_o` and `ack_o[cur_id]`.
  - `last_id <= cur_id`, `xfer_cnt_o` increments.
  - Go to ACK.
- **ACK:** deassert pulses, go to IDLE. Requests are not sampled in this state, which gives the acknowledged requester one edge to drop `req_i`.
- **Requester protocol:**
  - Hold `req_i` and data stable until `ack_o` is seen.
  - Deassert `req_i` on the edge that ends the ack cycle, or keep it high to request again.
- **Error:** if `req_i[cur_id]` is low during EXEC, set `err_o`. The transaction still completes and is still acknowledged.
- Data changing after the grant is ignored, because the operand was latched in IDLE.
- A requester that holds `req_i` high continuously is served once per round and cannot starve the others.
- Indices ≥ NREQ are never granted, including when NREQ is not a power of two.

## Timing
- **Reset values** (asynchronous assertion): state IDLE, `ack_o`=0, `res_o`=8'h00, `res_valid_o`=0, `res_id_o`=0, `busy_o`=0, `xfer_cnt_o`=0, `err_o`=0, `last_id`=NREQ-1 (so requester 0 wins first), operand=0.
- **Reset mid-transaction:** the transaction is aborted, no ack is issued, and the counter is not incremented.
- **Latency:** with `req_i` high at IDLE edge k, `ack_o` and `res_valid_o` are high during the cycle following edge k+1.
- **Throughput:** one transaction per 3 cycles. The period is exactly 3 under continuous requests.
- **Simultaneous requests:** only the winner latches. The others wait, with latency ≤ 3·NREQ cycles from the sampled request.
- **Wrap-around:** the round-robin pointer wraps from NREQ-1 to 0, and the counter wraps silently.

## Test plan
- Reset, then `req_i[2]`=1 with data 8'h3C → two cycles later `ack_o`=4'b0100, `res_o`=8'hC3, `res_id_o`=2, `xfer_cnt_o`=1.
- All four requests held high, data n = 8'h10+n → acks in order 0,1,2,3,0,… spaced 3 cycles apart, `res_o` = 8'hEF, 8'hEE, 8'hED, 8'hEC.
- `last_id`=3 with only `req_i[1]` and `req_i[3]` high → 1 is granted before 3; then 3, then 1 again.
- Requester drops `req_i` during EXEC → ack still issued, `err_o`=1, and it stays 1 until `rst`.
- Assert `rst` in the EXEC cycle → no `ack_o`, all outputs at their reset values; after release, requester 0 is granted first.
- Preload 65535 transactions (or force the counter) and run one more → `xfer_cnt_o`=0. Change `data_i` after the grant → `res_o` reflects the latched value.

Source files
------------

// File: rtl/comb_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : comb_share_arbiter (with helper comb00)
//  Purpose  : Round-robin arbiter time-sharing one comb00 inverter stage among
//             NREQ requesters. A granted operand is latched, inverted by the
//             shared stage and returned as a registered result. The result is
//             accompanied by a one-cycle one-hot acknowledge.
//  Ports    : clk, rst (async, active-high)
//             req_i[NREQ]      level requests
//             data_i[8*NREQ]   operands, requester n on [8n+7:8n]
//             ack_o[NREQ]      one-hot completion pulse
//             res_o[8]         registered result, holds until next completion
//             res_valid_o      pulse coincident with ack_o
//             res_id_o[IDW]    index of acknowledged requester, holds
//             busy_o           high in EXEC and ACK
//             xfer_cnt_o[16]   completed transactions, wrapping
//             err_o            sticky protocol error
//  Revision : 1.0 - initial release
// ============================================================================

// Shared datapath stage: plain 8-bit inverter.
module comb00 (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  assign y_o = ~a_i;
endmodule

module comb_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] data_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [7:0]        res_o,
  output logic              res_valid_o,
  output logic [IDW-1:0]    res_id_o,
  output logic              busy_o,
  output logic [15:0]       xfer_cnt_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e            state_q,   state_d;
  logic [7:0]        operand_q, operand_d;
  logic [IDW-1:0]    cur_id_q,  cur_id_d;
  logic [IDW-1:0]    last_id_q, last_id_d;
  logic [7:0]        res_q,     res_d;
  logic [IDW-1:0]    res_id_q,  res_id_d;
  logic [NREQ-1:0]   ack_q,     ack_d;
  logic              valid_q,   valid_d;
  logic [15:0]       xfer_q,    xfer_d;
  logic              err_q,     err_d;

  logic [7:0]        inv_w;
  logic [IDW-1:0]    winner_w;
  logic              any_req_w;
  logic [7:0]        sel_data_w;
  logic [NREQ-1:0]   cur_onehot_w;

  comb00 u_comb00 (
    .a_i (operand_q),
    .y_o (inv_w)
  );

  // Round-robin pick without modulo arithmetic: the lowest requester above
  // last_id wins; if none is above, the lowest requester overall wins. Loop
  // bounds keep indices >= NREQ out of reach.
  always_comb begin
    logic [IDW-1:0] lo_idx;
    logic [IDW-1:0] hi_idx;
    logic           hi_found;
    lo_idx   = '0;
    hi_idx   = '0;
    hi_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx = IDW'(i);
        if (IDW'(i) > last_id_q) begin
          hi_idx   = IDW'(i);
          hi_found = 1'b1;
        end
      end
    end
    winner_w  = hi_found ? hi_idx : lo_idx;
    any_req_w = |req_i;
  end

  // Operand mux and one-hot decode of the current id.
  always_comb begin
    sel_data_w   = '0;
    cur_onehot_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner_w == IDW'(i)) sel_data_w = data_i[8*i +: 8];
      cur_onehot_w[i] = (cur_id_q == IDW'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    cur_id_d  = cur_id_q;
    last_id_d = last_id_q;
    res_d     = res_q;
    res_id_d  = res_id_q;
    ack_d     = '0;
    valid_d   = 1'b0;
    xfer_d    = xfer_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (any_req_w) begin
          operand_d = sel_data_w;
          cur_id_d  = winner_w;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d     = inv_w;
        res_id_d  = cur_id_q;
        ack_d     = cur_onehot_w;
        valid_d   = 1'b1;
        last_id_d = cur_id_q;
        xfer_d    = xfer_q + 16'd1;
        // Requester withdrew before its ack: flag it, but still complete.
        if ((req_i & cur_onehot_w) == '0) err_d = 1'b1;
        state_d   = S_ACK;
      end
      S_ACK: begin
        // Requests deliberately ignored here so the acked requester can drop.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      operand_q <= '0;
      cur_id_q  <= '0;
      last_id_q <= IDW'(NREQ - 1);
      res_q     <= '0;
      res_id_q  <= '0;
      ack_q     <= '0;
      valid_q   <= 1'b0;
      xfer_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      cur_id_q  <= cur_id_d;
      last_id_q <= last_id_d;
      res_q     <= res_d;
      res_id_q  <= res_id_d;
      ack_q     <= ack_d;
      valid_q   <= valid_d;
      xfer_q    <= xfer_d;
      err_q     <= err_d;
    end
  end

  assign ack_o       = ack_q;
  assign res_o       = res_q;
  assign res_valid_o = valid_q;
  assign res_id_o    = res_id_q;
  assign busy_o      = (state_q != S_IDLE);
  assign xfer_cnt_o  = xfer_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_comb_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_comb_share_arbiter
//  Purpose  : Directed self-checking bench for comb_share_arbiter (NREQ=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_comb_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_i;
  logic [8*NREQ-1:0] data_i;
  logic [NREQ-1:0]   ack_o;
  logic [7:0]        res_o;
  logic              res_valid_o;
  logic [IDW-1:0]    res_id_o;
  logic              busy_o;
  logic [15:0]       xfer_cnt_o;
  logic              err_o;

  int n_tests = 0;
  int n_fail  = 0;

  comb_share_arbiter #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .data_i      (data_i),
    .ack_o       (ack_o),
    .res_o       (res_o),
    .res_valid_o (res_valid_o),
    .res_id_o    (res_id_o),
    .busy_o      (busy_o),
    .xfer_cnt_o  (xfer_cnt_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step negedges until res_valid_o is seen; n = negedges taken.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid_o && n < 20);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ack"},   32'(ack_o),       32'h0);
    check({tag, "_res"},   32'(res_o),       32'h0);
    check({tag, "_valid"}, 32'(res_valid_o), 32'h0);
    check({tag, "_id"},    32'(res_id_o),    32'h0);
    check({tag, "_busy"},  32'(busy_o),      32'h0);
    check({tag, "_cnt"},   32'(xfer_cnt_o),  32'h0);
    check({tag, "_err"},   32'(err_o),       32'h0);
  endtask

  int n;
  int rr_ids [3] = '{1, 3, 1};
  logic [7:0] rr_res [3] = '{8'hEE, 8'hEC, 8'hEE};

  initial begin
    rst    = 1'b1;
    req_i  = '0;
    data_i = '0;
    @(negedge clk);
    check_reset_state("rst0");
    @(negedge clk);
    rst = 1'b0;

    // Single request from requester 2.
    req_i  = 4'b0100;
    data_i = 32'h003C_0000;
    wait_valid(n);
    check("t1_lat",   32'(n),          32'd2);
    check("t1_ack",   32'(ack_o),      32'h4);
    check("t1_res",   32'(res_o),      32'hC3);
    check("t1_id",    32'(res_id_o),   32'd2);
    check("t1_cnt",   32'(xfer_cnt_o), 32'd1);
    check("t1_busy",  32'(busy_o),     32'd1);
    req_i = '0;
    @(negedge clk);
    check("t1_pulse", 32'(res_valid_o), 32'd0);
    check("t1_hold",  32'(res_o),       32'hC3);
    check("t1_idle",  32'(busy_o),      32'd0);

    // All four requesting: strict 0,1,2,3 order, period 3.
    do_reset();
    req_i  = 4'b1111;
    data_i = 32'h1312_1110;
    for (int k = 0; k < 4; k++) begin
      wait_valid(n);
      check("rr_lat", 32'(n),          (k == 0) ? 32'd2 : 32'd3);
      check("rr_ack", 32'(ack_o),      32'(1 << k));
      check("rr_res", 32'(res_o),      32'(8'hEF - k));
      check("rr_id",  32'(res_id_o),   32'(k));
      check("rr_cnt", 32'(xfer_cnt_o), 32'(k + 1));
    end

    // last_id = 3, only 1 and 3 requesting: 1, 3, 1.
    req_i = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      wait_valid(n);
      check("p2_lat", 32'(n),          32'd3);
      check("p2_id",  32'(res_id_o),   32'(rr_ids[k]));
      check("p2_res", 32'(res_o),      32'(rr_res[k]));
      check("p2_cnt", 32'(xfer_cnt_o), 32'(k + 5));
    end
    req_i = '0;

    // Requester 0 drops req during EXEC and changes its data.
    @(negedge clk);
    check("e_preerr", 32'(err_o), 32'd0);
    req_i  = 4'b0001;
    data_i = 32'h0000_00A5;
    @(negedge clk);
    check("e_busy", 32'(busy_o), 32'd1);
    req_i  = '0;
    data_i = '0;
    @(negedge clk);
    check("e_valid", 32'(res_valid_o), 32'd1);
    check("e_ack",   32'(ack_o),       32'h1);
    check("e_res",   32'(res_o),       32'h5A);
    check("e_err",   32'(err_o),       32'd1);
    check("e_cnt",   32'(xfer_cnt_o),  32'd8);
    @(negedge clk);
    check("e_sticky", 32'(err_o), 32'd1);
    req_i  = 4'b0100;
    data_i = 32'h0001_0000;
    wait_valid(n);
    check("e2_res",    32'(res_o),      32'hFE);
    check("e2_sticky", 32'(err_o),      32'd1);
    check("e2_cnt",    32'(xfer_cnt_o), 32'd9);
    req_i = '0;

    // Reset asserted during EXEC aborts the transaction.
    @(negedge clk);
    req_i  = 4'b0001;
    data_i = 32'h0000_0077;
    @(negedge clk);
    check("r_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_state("rmid");
    @(negedge clk);
    check("r_noack", 32'(ack_o), 32'h0);
    rst    = 1'b0;
    req_i  = 4'b0101;
    data_i = 32'h0055_0077;
    wait_valid(n);
    check("r_lat", 32'(n),          32'd2);
    check("r_ack", 32'(ack_o),      32'h1);
    check("r_res", 32'(res_o),      32'h88);
    check("r_cnt", 32'(xfer_cnt_o), 32'd1);
    req_i = '0;

    // Counter wrap from 0xFFFF.
    @(negedge clk);
    force dut.xfer_q = 16'hFFFF;
    @(negedge clk);
    release dut.xfer_q;
    check("w_pre", 32'(xfer_cnt_o), 32'hFFFF);
    req_i  = 4'b0010;
    data_i = 32'h0000_0000;
    wait_valid(n);
    check("w_cnt", 32'(xfer_cnt_o), 32'h0);
    check("w_res", 32'(res_o),      32'hFF);
    check("w_id",  32'(res_id_o),   32'd1);
    req_i = '0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
